mdu_pipelined: RTL and testbench



---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_result_calc.sv | 49 ++++
 rtl/mdu_pipelined.sv | 128 ++++++++++++
 tb/tb_mdu_pipelined.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the MDU: op encodings, FSM state encoding and default latencies.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_MADD  = 3'd6,
        MDU_MADDU = 3'd7
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_result_calc.sv
// Combinational product / quotient / remainder for the latched MDU operands.
// Signedness is taken from the op; the divisor is forced to 1 on divide-by-zero to keep the divider well defined.
module mdu_result_calc
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  mdu_op_e            i_op,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_prod,
    output logic [WIDTH-1:0]   o_quot,
    output logic [WIDTH-1:0]   o_rem,
    output logic               o_div_zero
);

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_divisor;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;

    always_comb begin
        w_signed = (i_op == MDU_MULT) || (i_op == MDU_DIV) || (i_op == MDU_MADD);

        // Sign-extending to 2*WIDTH makes the truncated product correct for both signednesses.
        w_a_ext = {{WIDTH{w_signed & i_a[WIDTH-1]}}, i_a};
        w_b_ext = {{WIDTH{w_signed & i_b[WIDTH-1]}}, i_b};
        o_prod  = w_a_ext * w_b_ext;

        w_a_neg    = w_signed & i_a[WIDTH-1];
        w_b_neg    = w_signed & i_b[WIDTH-1];
        w_a_mag    = w_a_neg ? -i_a : i_a;
        w_b_mag    = w_b_neg ? -i_b : i_b;
        o_div_zero = (i_b == '0);
        w_divisor  = o_div_zero ? WIDTH'(1) : w_b_mag;

        w_q_mag = w_a_mag / w_divisor;
        w_r_mag = w_a_mag % w_divisor;
        o_quot  = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
        o_rem   = w_a_neg ? -w_r_mag : w_r_mag;
    end

endmodule

// File: rtl/mdu_pipelined.sv
// Multi-cycle multiply/divide unit with HI/LO registers; busy drives the EX-stage stall logic.
// Define MDU_MADD_EN to enable MADD/MADDU (ops 6/7); otherwise those encodings are ignored.
module mdu_pipelined
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

    mdu_state_e r_state;
    mdu_state_e w_next_state;
    logic [CW-1:0]    r_cnt;
    mdu_op_e          r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    mdu_op_e            w_op;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_is_madd;
    logic               w_idle_start;
    logic               w_launch;
    logic               w_commit;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic               w_div_zero;

    mdu_result_calc #(.WIDTH(WIDTH)) u_calc (
        .i_op       (r_op),
        .i_a        (r_a),
        .i_b        (r_b),
        .o_prod     (w_prod),
        .o_quot     (w_quot),
        .o_rem      (w_rem),
        .o_div_zero (w_div_zero)
    );

    always_comb begin
        w_op     = mdu_op_e'(op);
        w_is_mul = (w_op == MDU_MULT) || (w_op == MDU_MULTU);
        w_is_div = (w_op == MDU_DIV) || (w_op == MDU_DIVU);
`ifdef MDU_MADD_EN
        w_is_madd = (w_op == MDU_MADD) || (w_op == MDU_MADDU);
`else
        w_is_madd = 1'b0;
`endif
        w_idle_start = start && (r_state == IDLE);
        w_launch     = w_idle_start && (w_is_mul || w_is_div || w_is_madd);
        w_commit     = (r_state == RUN) && (r_cnt == CW'(1));
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        case (r_state)
            IDLE: if (w_launch) w_next_state = RUN;
            RUN: begin
                busy = 1'b1;
                if (w_commit) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_op  <= MDU_MULT;
            r_a   <= '0;
            r_b   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else if (w_launch) begin
            r_cnt <= w_is_div ? DIV_LOAD : MULT_LOAD;
            r_op  <= w_op;
            r_a   <= a;
            r_b   <= b;
        end else if (w_idle_start) begin
            if (w_op == MDU_MTHI) r_hi <= a;
            if (w_op == MDU_MTLO) r_lo <= a;
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt - CW'(1);
            if (w_commit) begin
                case (r_op)
                    MDU_MULT, MDU_MULTU: {r_hi, r_lo} <= w_prod;
                    MDU_DIV, MDU_DIVU: begin
                        if (!w_div_zero) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                    end
`ifdef MDU_MADD_EN
                    MDU_MADD, MDU_MADDU: {r_hi, r_lo} <= {r_hi, r_lo} + w_prod;
`endif
                    default: ;
                endcase
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: tb/tb_mdu_pipelined.sv
// Directed self-checking bench for mdu_pipelined (default latencies 5/10, WIDTH 32).
module tb_mdu_pipelined;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total = 0;
    int bad   = 0;

    mdu_pipelined #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b, ph, pl, eh, el;
        int           n;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (3) tick();
        total++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
            bad++;
            $display("FAIL reset: busy=%b hi=%h lo=%h, required busy=0 hi=0 lo=0", busy, hi, lo);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_mthi_mtlo();
        issue(3'd4, 32'hDEADBEEF, '0);
        total++;
        if (busy !== 1'b0 || hi !== 32'hDEADBEEF || lo !== '0) begin
            bad++;
            $display("FAIL mthi: busy=%b hi=%h lo=%h, required busy=0 hi=deadbeef lo=0", busy, hi, lo);
        end
        issue(3'd5, 32'h12345678, '0);
        total++;
        if (busy !== 1'b0 || hi !== 32'hDEADBEEF || lo !== 32'h12345678) begin
            bad++;
            $display("FAIL mtlo: busy=%b hi=%h lo=%h, required busy=0 hi=deadbeef lo=12345678", busy, hi, lo);
        end
    endtask

    task automatic test_arith();
        vec_t v[11];
        v[0]  = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, MC};
        v[1]  = '{3'd0, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1, 32'h2, 32'h00000000, 32'h00000006, MC};
        v[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, MC};
        v[3]  = '{3'd1, 32'h00010000, 32'h00010000, 32'h5, 32'h6, 32'h00000001, 32'h00000000, MC};
        v[4]  = '{3'd3, 32'd100,      32'd7,        32'h0, 32'h0, 32'd2,        32'd14,       DC};
        v[5]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        v[6]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFD, DC};
        v[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h9, 32'h9, 32'h00000000, 32'h80000000, DC};
        v[8]  = '{3'd2, 32'd5,        32'd0,        32'h11, 32'h22, 32'h11,     32'h22,       DC};
        v[9]  = '{3'd3, 32'hFFFFFFFF, 32'd0,        32'h33, 32'h44, 32'h33,     32'h44,       DC};
        v[10] = '{3'd3, 32'hFFFFFFFF, 32'd10,       32'h0, 32'h0, 32'd5,        32'h19999999, DC};
        for (int i = 0; i < 11; i++) begin
            issue(3'd4, v[i].ph, '0);
            issue(3'd5, v[i].pl, '0);
            issue(v[i].op, v[i].a, v[i].b);
            for (int c = 0; c < v[i].n; c++) begin
                total++;
                if (busy !== 1'b1 || hi !== v[i].ph || lo !== v[i].pl) begin
                    bad++;
                    $display("FAIL arith[%0d] run cycle %0d: busy=%b hi=%h lo=%h, required busy=1 hi=%h lo=%h",
                             i, c + 1, busy, hi, lo, v[i].ph, v[i].pl);
                end
                tick();
            end
            total++;
            if (busy !== 1'b0 || hi !== v[i].eh || lo !== v[i].el) begin
                bad++;
                $display("FAIL arith[%0d] result: busy=%b hi=%h lo=%h, required busy=0 hi=%h lo=%h",
                         i, busy, hi, lo, v[i].eh, v[i].el);
            end
        end
    endtask

    task automatic test_back_to_back();
        issue(3'd4, '0, '0);
        issue(3'd5, '0, '0);
        issue(3'd0, 32'd3, 32'd4);
        tick();
        issue(3'd3, 32'd100, 32'd7);
        repeat (MC - 2) tick();
        total++;
        if (busy !== 1'b0 || hi !== '0 || lo !== 32'd12) begin
            bad++;
            $display("FAIL start_while_busy: busy=%b hi=%h lo=%h, required busy=0 hi=0 lo=c", busy, hi, lo);
        end
        tick();
        total++;
        if (busy !== 1'b0 || lo !== 32'd12) begin
            bad++;
            $display("FAIL no_restart: busy=%b lo=%h, required busy=0 lo=c", busy, lo);
        end
    endtask

    task automatic test_abort();
        issue(3'd4, 32'd7, '0);
        issue(3'd5, 32'd9, '0);
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(3'd5, 32'd5, '0);
        total++;
        if (busy !== 1'b1 || hi !== 32'd7 || lo !== 32'd9) begin
            bad++;
            $display("FAIL mtlo_mid_run: busy=%b hi=%h lo=%h, required busy=1 hi=7 lo=9", busy, hi, lo);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
            bad++;
            $display("FAIL abort_reset: busy=%b hi=%h lo=%h, required busy=0 hi=0 lo=0", busy, hi, lo);
        end
        repeat (6) tick();
        total++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
            bad++;
            $display("FAIL abort_discard: busy=%b hi=%h lo=%h, required busy=0 hi=0 lo=0", busy, hi, lo);
        end
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (MC) tick();
        total++;
        if (busy !== 1'b0 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            bad++;
            $display("FAIL abort_rerun: busy=%b hi=%h lo=%h, required busy=0 hi=fffffffe lo=1", busy, hi, lo);
        end
    endtask

    task automatic test_reset_start();
        issue(3'd4, 32'hAA, '0);
        reset = 1'b1;
        start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
        tick();
        reset = 1'b0; start = 1'b0;
        total++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
            bad++;
            $display("FAIL reset_and_start: busy=%b hi=%h lo=%h, required busy=0 hi=0 lo=0", busy, hi, lo);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_and_start_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_op6_op7();
        issue(3'd4, '0, '0);
        issue(3'd5, 32'd10, '0);
        issue(3'd6, 32'd3, 32'hFFFFFFFC);
`ifdef MDU_MADD_EN
        repeat (MC) tick();
        total++;
        if (busy !== 1'b0 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin
            bad++;
            $display("FAIL madd: busy=%b hi=%h lo=%h, required busy=0 hi=ffffffff lo=fffffffe", busy, hi, lo);
        end
        issue(3'd4, '0, '0);
        issue(3'd5, 32'd10, '0);
        issue(3'd7, 32'd3, 32'hFFFFFFFC);
        repeat (MC) tick();
        total++;
        if (busy !== 1'b0 || hi !== 32'h00000002 || lo !== 32'hFFFFFFFE) begin
            bad++;
            $display("FAIL maddu: busy=%b hi=%h lo=%h, required busy=0 hi=2 lo=fffffffe", busy, hi, lo);
        end
`else
        total++;
        if (busy !== 1'b0 || hi !== '0 || lo !== 32'd10) begin
            bad++;
            $display("FAIL op6_ignored: busy=%b hi=%h lo=%h, required busy=0 hi=0 lo=a", busy, hi, lo);
        end
        issue(3'd7, 32'd3, 32'hFFFFFFFC);
        tick();
        total++;
        if (busy !== 1'b0 || hi !== '0 || lo !== 32'd10) begin
            bad++;
            $display("FAIL op7_ignored: busy=%b hi=%h lo=%h, required busy=0 hi=0 lo=a", busy, hi, lo);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_mthi_mtlo();
        test_arith();
        test_back_to_back();
        test_abort();
        test_reset_start();
        test_op6_op7();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
